// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider: one shift/subtract step per cycle on the
// magnitudes, sign correction and special cases resolved in a final FIX cycle.
module booth_seq_divider #(
  parameter int WIDTH_DIV = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH_DIV-1:0] i_dividend,
  input  logic [WIDTH_DIV-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH_DIV-1:0] o_quotient,
  output logic [WIDTH_DIV-1:0] o_remainder,
  output logic                 o_div_by_zero,
  output logic                 o_overflow
);

  localparam int unsigned CW = $clog2(WIDTH_DIV + 1);
  localparam logic [WIDTH_DIV-1:0] MIN_NEG = {1'b1, {(WIDTH_DIV-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [WIDTH_DIV-1:0] q_reg;
  logic [WIDTH_DIV-1:0] d_reg;
  // Partial remainder is always below the divisor magnitude (<= 2^(W-1)), so the
  // top bit of the nominal W+1-bit remainder is never set and is not stored.
  logic [WIDTH_DIV-1:0] r_reg;
  logic [CW-1:0]        cnt;
  logic                 sign_a;
  logic                 sign_b;
  logic                 dz_hold;
  logic                 ov_hold;
  logic [WIDTH_DIV-1:0] dividend_hold;

  logic [WIDTH_DIV:0]   t;

  always_comb begin
    t = {r_reg, q_reg[WIDTH_DIV-1]} - {1'b0, d_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt           <= '0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      dz_hold       <= 1'b0;
      ov_hold       <= 1'b0;
      dividend_hold <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            sign_a        <= i_dividend[WIDTH_DIV-1];
            sign_b        <= i_divisor[WIDTH_DIV-1];
            q_reg         <= i_dividend[WIDTH_DIV-1] ? -i_dividend : i_dividend;
            d_reg         <= i_divisor[WIDTH_DIV-1]  ? -i_divisor  : i_divisor;
            r_reg         <= '0;
            cnt           <= '0;
            dividend_hold <= i_dividend;
            dz_hold       <= (i_divisor == '0);
            ov_hold       <= (i_dividend == MIN_NEG) && (i_divisor == '1);
            o_busy        <= 1'b1;
            state         <= CALC;
          end
        end
        CALC: begin
          // The extra settle cycle at cnt == WIDTH_DIV keeps done on edge W+2.
          if (cnt == CW'(WIDTH_DIV)) begin
            state <= FIX;
          end else begin
            if (t[WIDTH_DIV]) begin
              r_reg <= {r_reg[WIDTH_DIV-2:0], q_reg[WIDTH_DIV-1]};
              q_reg <= {q_reg[WIDTH_DIV-2:0], 1'b0};
            end else begin
              r_reg <= t[WIDTH_DIV-1:0];
              q_reg <= {q_reg[WIDTH_DIV-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (dz_hold) begin
            o_quotient    <= '1;
            o_remainder   <= dividend_hold;
            o_div_by_zero <= 1'b1;
            o_overflow    <= 1'b0;
          end else if (ov_hold) begin
            o_quotient    <= MIN_NEG;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b1;
          end else begin
            o_quotient    <= (sign_a ^ sign_b) ? -q_reg : q_reg;
            o_remainder   <= sign_a ? -r_reg : r_reg;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
          end
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
